// File: rtl/fwd_hazard_sb.sv
// EX-stage forwarding and hazard unit. Each source operand gets its own
// forwarding/hazard lane. A single multi-cycle unit (div/mul) is tracked by
// a one-entry scoreboard with a latency down-counter. The stall output is
// purely combinational, and stalled cycles are counted with saturation.

module fwd_hazard_lane #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] rs,
    input  logic               used,
    input  logic [XLEN-1:0]    rf_data,
    input  logic [RADDR_W-1:0] ex_mem_rd,
    input  logic               ex_mem_rwen,
    input  logic               ex_mem_is_load,
    input  logic [XLEN-1:0]    ex_mem_data,
    input  logic [RADDR_W-1:0] mem_wb_rd,
    input  logic               mem_wb_rwen,
    input  logic [XLEN-1:0]    mem_wb_data,
    input  logic               mc_busy,
    input  logic               mc_done,
    input  logic [RADDR_W-1:0] mc_rd_q,
    input  logic [XLEN-1:0]    mc_data,
    output logic [1:0]         sel,
    output logic [XLEN-1:0]    data,
    output logic               hazard
);
    logic ex_hit, wb_hit, mc_hit;

    // Nonzero destination matches; register 0 never forwards or stalls.
    assign ex_hit = ex_mem_rwen && (ex_mem_rd != '0) && (ex_mem_rd == rs);
    assign wb_hit = mem_wb_rwen && (mem_wb_rd != '0) && (mem_wb_rd == rs);
    assign mc_hit = (mc_rd_q != '0) && (mc_rd_q == rs);

    // Priority mux: youngest producer first; a load in EX/MEM has no data yet.
    always_comb begin
        sel  = 2'b00;
        data = rf_data;
        if (ex_hit && !ex_mem_is_load) begin
            sel  = 2'b01;
            data = ex_mem_data;
        end else if (wb_hit) begin
            sel  = 2'b10;
            data = mem_wb_data;
        end else if (mc_done && mc_hit) begin
            sel  = 2'b11;
            data = mc_data;
        end
    end

    // RAW hazards only matter when the instruction actually reads the operand.
    always_comb begin
        hazard = used && ((ex_hit && ex_mem_is_load) || (mc_busy && !mc_done && mc_hit));
    end
endmodule

module fwd_hazard_sb #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5,
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 4,
    parameter int CNT_W   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*RADDR_W-1:0] src_rs,
    input  logic [NUM_SRC-1:0]         src_used,
    input  logic [NUM_SRC*XLEN-1:0]    src_rf_data,
    input  logic [RADDR_W-1:0]         ex_mem_rd,
    input  logic                       ex_mem_rwen,
    input  logic                       ex_mem_is_load,
    input  logic [XLEN-1:0]            ex_mem_data,
    input  logic [RADDR_W-1:0]         mem_wb_rd,
    input  logic                       mem_wb_rwen,
    input  logic [XLEN-1:0]            mem_wb_data,
    input  logic                       mc_issue,
    input  logic [RADDR_W-1:0]         mc_rd,
    input  logic [LAT_W-1:0]           mc_lat,
    input  logic [XLEN-1:0]            mc_data,
    output logic [NUM_SRC*2-1:0]       fwd_sel,
    output logic [NUM_SRC*XLEN-1:0]    src_data,
    output logic                       stall,
    output logic                       mc_ready,
    output logic                       mc_done,
    output logic [CNT_W-1:0]           stall_cnt
);
    logic               mc_busy;
    logic [LAT_W-1:0]   mc_cnt;
    logic [RADDR_W-1:0] mc_rd_q;
    logic [NUM_SRC-1:0] lane_haz;
    logic               mc_accept;

    assign mc_done   = mc_busy && (mc_cnt == LAT_W'(1));
    assign mc_ready  = !mc_busy || mc_done;
    assign mc_accept = mc_issue && mc_ready;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_lane
            fwd_hazard_lane #(
                .XLEN    (XLEN),
                .RADDR_W (RADDR_W)
            ) u_lane (
                .rs             (src_rs[g*RADDR_W +: RADDR_W]),
                .used           (src_used[g]),
                .rf_data        (src_rf_data[g*XLEN +: XLEN]),
                .ex_mem_rd      (ex_mem_rd),
                .ex_mem_rwen    (ex_mem_rwen),
                .ex_mem_is_load (ex_mem_is_load),
                .ex_mem_data    (ex_mem_data),
                .mem_wb_rd      (mem_wb_rd),
                .mem_wb_rwen    (mem_wb_rwen),
                .mem_wb_data    (mem_wb_data),
                .mc_busy        (mc_busy),
                .mc_done        (mc_done),
                .mc_rd_q        (mc_rd_q),
                .mc_data        (mc_data),
                .sel            (fwd_sel[g*2 +: 2]),
                .data           (src_data[g*XLEN +: XLEN]),
                .hazard         (lane_haz[g])
            );
        end
    endgenerate

    // Any operand RAW hazard or an issue the busy unit cannot take holds the front end.
    always_comb begin
        stall = (|lane_haz) || (mc_issue && !mc_ready);
    end

    // Scoreboard: a new accepted issue always wins over the retiring op.
    always_ff @(posedge clk) begin
        if (rst) begin
            mc_busy <= 1'b0;
            mc_cnt  <= '0;
            mc_rd_q <= '0;
        end else if (mc_accept) begin
            mc_busy <= 1'b1;
            mc_rd_q <= mc_rd;
            mc_cnt  <= (mc_lat == '0) ? LAT_W'(1) : mc_lat;
        end else if (mc_busy) begin
            mc_cnt <= mc_cnt - LAT_W'(1);
            if (mc_done) mc_busy <= 1'b0;
        end
    end

    // Saturating stall-cycle counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)                           stall_cnt <= '0;
        else if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_fwd_hazard_sb.sv
// Directed bench for fwd_hazard_sb: forwarding priority, load-use, multi-cycle
// scoreboard, structural hazard, counter saturation and mid-op reset.

module tb_fwd_hazard_sb;
    localparam int XLEN = 32, RADDR_W = 5, NUM_SRC = 2, LAT_W = 4, CNT_W = 4;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_SRC*RADDR_W-1:0] src_rs;
    logic [NUM_SRC-1:0]         src_used;
    logic [NUM_SRC*XLEN-1:0]    src_rf_data;
    logic [RADDR_W-1:0]         ex_mem_rd;
    logic                       ex_mem_rwen;
    logic                       ex_mem_is_load;
    logic [XLEN-1:0]            ex_mem_data;
    logic [RADDR_W-1:0]         mem_wb_rd;
    logic                       mem_wb_rwen;
    logic [XLEN-1:0]            mem_wb_data;
    logic                       mc_issue;
    logic [RADDR_W-1:0]         mc_rd;
    logic [LAT_W-1:0]           mc_lat;
    logic [XLEN-1:0]            mc_data;
    logic [NUM_SRC*2-1:0]       fwd_sel;
    logic [NUM_SRC*XLEN-1:0]    src_data;
    logic                       stall;
    logic                       mc_ready;
    logic                       mc_done;
    logic [CNT_W-1:0]           stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_sb #(
        .XLEN(XLEN), .RADDR_W(RADDR_W), .NUM_SRC(NUM_SRC), .LAT_W(LAT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .src_rs(src_rs), .src_used(src_used), .src_rf_data(src_rf_data),
        .ex_mem_rd(ex_mem_rd), .ex_mem_rwen(ex_mem_rwen), .ex_mem_is_load(ex_mem_is_load),
        .ex_mem_data(ex_mem_data), .mem_wb_rd(mem_wb_rd), .mem_wb_rwen(mem_wb_rwen),
        .mem_wb_data(mem_wb_data), .mc_issue(mc_issue), .mc_rd(mc_rd), .mc_lat(mc_lat),
        .mc_data(mc_data), .fwd_sel(fwd_sel), .src_data(src_data), .stall(stall),
        .mc_ready(mc_ready), .mc_done(mc_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        src_rs = '0; src_used = '0; src_rf_data = {32'h1111_0002, 32'h1111_0001};
        ex_mem_rd = '0; ex_mem_rwen = 0; ex_mem_is_load = 0; ex_mem_data = '0;
        mem_wb_rd = '0; mem_wb_rwen = 0; mem_wb_data = '0;
        mc_issue = 0; mc_rd = '0; mc_lat = '0; mc_data = 32'hDEAD;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (mc_ready !== 1'b1 || mc_done !== 1'b0 || stall !== 1'b0 || stall_cnt !== 4'h0) begin
            n_fail++;
            $display("FAIL reset: ready=%b done=%b stall=%b cnt=%h, want 1 0 0 0",
                     mc_ready, mc_done, stall, stall_cnt);
        end
    endtask

    task automatic test_forward();
        do_reset();
        // EX/MEM beats MEM/WB on the same register.
        src_rs = {5'd5, 5'd5}; src_used = 2'b11;
        ex_mem_rd = 5'd5; ex_mem_rwen = 1; ex_mem_data = 32'hAAAA;
        mem_wb_rd = 5'd5; mem_wb_rwen = 1; mem_wb_data = 32'hBBBB;
        #1;
        n_checks++;
        if (fwd_sel !== 4'b0101 || src_data !== {32'hAAAA, 32'hAAAA} || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_exmem: sel=%b data=%h stall=%b, want 0101 0000aaaa0000aaaa 0",
                     fwd_sel, src_data, stall);
        end
        // EX/MEM not writing: MEM/WB forwards.
        ex_mem_rwen = 0;
        #1;
        n_checks++;
        if (fwd_sel !== 4'b1010 || src_data !== {32'hBBBB, 32'hBBBB}) begin
            n_fail++;
            $display("FAIL fwd_memwb: sel=%b data=%h, want 1010 0000bbbb0000bbbb", fwd_sel, src_data);
        end
        // Register 0 never forwards.
        src_rs = {5'd3, 5'd0}; ex_mem_rd = 5'd0; ex_mem_rwen = 1; mem_wb_rwen = 0;
        #1;
        n_checks++;
        if (fwd_sel !== 4'b0000 || src_data !== {32'h1111_0002, 32'h1111_0001} || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL fwd_r0: sel=%b data=%h stall=%b, want 0000 1111000211110001 0",
                     fwd_sel, src_data, stall);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        src_rs = {5'd7, 5'd3}; src_used = 2'b01;
        ex_mem_rd = 5'd7; ex_mem_rwen = 1; ex_mem_is_load = 1; ex_mem_data = 32'h9999;
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_fail++;
            $display("FAIL load_use_unused: stall=%b, want 0", stall);
        end
        src_used = 2'b11;
        #1;
        n_checks++;
        if (stall !== 1'b1 || fwd_sel[3:2] !== 2'b00) begin
            n_fail++;
            $display("FAIL load_use_stall: stall=%b sel=%b, want 1 00", stall, fwd_sel[3:2]);
        end
        tick();
        ex_mem_rwen = 0; ex_mem_is_load = 0;
        mem_wb_rd = 5'd7; mem_wb_rwen = 1; mem_wb_data = 32'h1234;
        #1;
        n_checks++;
        if (stall_cnt !== 4'h1 || stall !== 1'b0 || fwd_sel[3:2] !== 2'b10 || src_data[63:32] !== 32'h1234) begin
            n_fail++;
            $display("FAIL load_use_after: cnt=%h stall=%b sel=%b data=%h, want 1 0 10 1234",
                     stall_cnt, stall, fwd_sel[3:2], src_data[63:32]);
        end
    endtask

    task automatic test_mc();
        do_reset();
        // cycle 0: issue rd=9 lat=3
        src_rs = {5'd0, 5'd9}; src_used = 2'b01;
        mc_issue = 1; mc_rd = 5'd9; mc_lat = 4'd3;
        #1;
        n_checks++;
        if (mc_ready !== 1'b1 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_issue0: ready=%b stall=%b, want 1 0", mc_ready, stall);
        end
        tick();
        // cycle 1: RAW stall, plus a rejected issue (rd=12 lat=1)
        mc_issue = 1; mc_rd = 5'd12; mc_lat = 4'd1;
        #1;
        n_checks++;
        if (stall !== 1'b1 || mc_ready !== 1'b0 || mc_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_cyc1: stall=%b ready=%b done=%b, want 1 0 0", stall, mc_ready, mc_done);
        end
        tick();
        // cycle 2: rejected issue left scoreboard alone
        mc_issue = 0;
        #1;
        n_checks++;
        if (stall !== 1'b1 || mc_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_cyc2: stall=%b done=%b, want 1 0", stall, mc_done);
        end
        tick();
        // cycle 3: done, forward from mc; back-to-back issue rd=10 lat=2
        mc_issue = 1; mc_rd = 5'd10; mc_lat = 4'd2;
        #1;
        n_checks++;
        if (mc_done !== 1'b1 || mc_ready !== 1'b1 || stall !== 1'b0 ||
            fwd_sel[1:0] !== 2'b11 || src_data[31:0] !== 32'hDEAD) begin
            n_fail++;
            $display("FAIL mc_done: done=%b ready=%b stall=%b sel=%b data=%h, want 1 1 0 11 dead",
                     mc_done, mc_ready, stall, fwd_sel[1:0], src_data[31:0]);
        end
        tick();
        // cycle 4: new op tracked, old rd no longer stalls
        mc_issue = 0;
        #1;
        n_checks++;
        if (mc_done !== 1'b0 || mc_ready !== 1'b0 || stall !== 1'b0 || stall_cnt !== 4'h2) begin
            n_fail++;
            $display("FAIL mc_b2b_old: done=%b ready=%b stall=%b cnt=%h, want 0 0 0 2",
                     mc_done, mc_ready, stall, stall_cnt);
        end
        src_rs = {5'd0, 5'd10};
        #1;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL mc_b2b_new: stall=%b, want 1", stall);
        end
        tick();
        // cycle 5: second op done
        #1;
        n_checks++;
        if (mc_done !== 1'b1 || fwd_sel[1:0] !== 2'b11 || stall !== 1'b0 || stall_cnt !== 4'h3) begin
            n_fail++;
            $display("FAIL mc_done2: done=%b sel=%b stall=%b cnt=%h, want 1 11 0 3",
                     mc_done, fwd_sel[1:0], stall, stall_cnt);
        end
        tick();
        n_checks++;
        if (mc_done !== 1'b0 || mc_ready !== 1'b1 || fwd_sel[1:0] !== 2'b00) begin
            n_fail++;
            $display("FAIL mc_idle: done=%b ready=%b sel=%b, want 0 1 00", mc_done, mc_ready, fwd_sel[1:0]);
        end
    endtask

    task automatic test_mc_edge();
        do_reset();
        // lat=0 behaves like lat=1; rd=0 occupies the unit but never hazards
        src_rs = {5'd0, 5'd0}; src_used = 2'b11;
        mc_issue = 1; mc_rd = 5'd0; mc_lat = 4'd0;
        tick();
        mc_issue = 0;
        #1;
        n_checks++;
        if (mc_done !== 1'b1 || stall !== 1'b0 || fwd_sel !== 4'b0000) begin
            n_fail++;
            $display("FAIL mc_lat0_rd0: done=%b stall=%b sel=%b, want 1 0 0000", mc_done, stall, fwd_sel);
        end
        tick();
        n_checks++;
        if (mc_done !== 1'b0 || mc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mc_lat0_after: done=%b ready=%b, want 0 1", mc_done, mc_ready);
        end
    endtask

    task automatic test_sat_and_reset();
        do_reset();
        src_rs = {5'd0, 5'd7}; src_used = 2'b01;
        ex_mem_rd = 5'd7; ex_mem_rwen = 1; ex_mem_is_load = 1;
        for (int i = 0; i < 18; i++) tick();
        n_checks++;
        if (stall_cnt !== 4'hF) begin
            n_fail++;
            $display("FAIL stall_sat: cnt=%h, want f", stall_cnt);
        end
        idle_inputs();
        mc_issue = 1; mc_rd = 5'd4; mc_lat = 4'd3;
        tick();
        mc_issue = 0;
        rst = 1;
        tick();
        rst = 0;
        #1;
        n_checks++;
        if (mc_ready !== 1'b1 || mc_done !== 1'b0 || stall_cnt !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_reset: ready=%b done=%b cnt=%h, want 1 0 0", mc_ready, mc_done, stall_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (mc_done !== 1'b0) begin
                n_fail++;
                $display("FAIL post_reset_done: cycle %0d done=%b, want 0", i, mc_done);
            end
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_mc();
        test_mc_edge();
        test_sat_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
